// File: rtl/dmem_responder.sv
// dmem_responder: word-wide data-memory target for the MEM stage.
// Accepts one request at a time over valid/ready, waits WAIT_CYCLES
// cycles, then returns read data plus an error flag.
//
// Parameters:
//   ADDR_WIDTH  - word-address width (1..29), depth = 2**ADDR_WIDTH
//   WAIT_CYCLES - wait states between accept and response (0..15)
// Ports:
//   i_clk, i_s_rst           - clock, synchronous active-high reset
//   i_req_valid/o_req_ready  - request handshake
//   i_req_we, i_req_addr     - write flag, byte address
//   i_req_wdata, i_req_be    - write data, byte enables
//   o_rsp_valid/i_rsp_ready  - response handshake
//   o_rsp_rdata, o_rsp_err   - read data, misaligned/out-of-range flag
//   o_busy                   - registered stall source (not IDLE)
// Build option:
//   DMEM_BYTE_WRITE_EN - when defined, writes honour i_req_be;
//                        otherwise every good write stores the full word.

module dmem_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        i_clk,
   input  logic        i_s_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [3:0]  i_req_be,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic        o_busy
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   logic [3:0] cnt;

   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic [31:0] mem [DEPTH];

   // With zero wait states the commit edge is the accept edge, so the
   // live request inputs feed the access instead of the captured copy.
   logic        c_we;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic        c_err;
   logic        commit;
   logic        wr_en;
   logic [31:0] rd_next;
   logic [ADDR_WIDTH-1:0] c_idx;

`ifdef DMEM_BYTE_WRITE_EN
   logic [3:0] req_be;
   logic [3:0] c_be;
`else
   logic unused_be;
   assign unused_be = ^i_req_be;
`endif

   always_comb begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
      c_be    = req_be;
`endif
      if (state == IDLE) begin
         c_we    = i_req_we;
         c_addr  = i_req_addr;
         c_wdata = i_req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
         c_be    = i_req_be;
`endif
      end
   end

   assign c_idx = c_addr[ADDR_WIDTH+1:2];
   assign c_err = (c_addr[1:0] != 2'b00) |
                  (|c_addr[31:ADDR_WIDTH+2]);

   // The edge that enters RESP is the commit edge; reset wins over it.
   always_comb begin
      commit = 1'b0;
      if (!i_s_rst) begin
         if (state == WAIT && cnt == 4'd0)
            commit = 1'b1;
         if (state == IDLE && i_req_valid && WAIT_CYCLES == 0)
            commit = 1'b1;
      end
   end

   assign wr_en   = commit & c_we & ~c_err;
   assign rd_next = (c_we | c_err) ? 32'd0 : mem[c_idx];

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
`ifdef DMEM_BYTE_WRITE_EN
         for (int b = 0; b < 4; b++) begin
            if (c_be[b])
               mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
         end
`else
         mem[c_idx] <= c_wdata;
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_s_rst) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         o_req_ready <= 1'b1;
         o_busy      <= 1'b0;
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= 32'd0;
         o_rsp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_req_valid) begin
                  req_we      <= i_req_we;
                  req_addr    <= i_req_addr;
                  req_wdata   <= i_req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
                  req_be      <= i_req_be;
`endif
                  o_req_ready <= 1'b0;
                  o_busy      <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state       <= RESP;
                     o_rsp_valid <= 1'b1;
                     o_rsp_rdata <= rd_next;
                     o_rsp_err   <= c_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= 4'(WAIT_CYCLES - 1);
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state       <= RESP;
                  o_rsp_valid <= 1'b1;
                  o_rsp_rdata <= rd_next;
                  o_rsp_err   <= c_err;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  state       <= IDLE;
                  o_rsp_valid <= 1'b0;
                  o_rsp_rdata <= 32'd0;
                  o_rsp_err   <= 1'b0;
                  o_req_ready <= 1'b1;
                  o_busy      <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               cnt         <= 4'd0;
               o_req_ready <= 1'b1;
               o_busy      <= 1'b0;
               o_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized bench with a transaction-level model
// of dmem_responder plus directed literal checks.

module tb_dmem_responder;

   localparam int AW = 10;
   localparam int W  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        i_s_rst;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_we;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic [3:0]  i_req_be;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;
   logic        o_busy;

   logic        f_rst;
   logic        f_valid;
   logic        f_ready;
   logic        f_we;
   logic [31:0] f_addr;
   logic [31:0] f_wdata;
   logic [3:0]  f_be;
   logic        f_rsp_valid;
   logic        f_rsp_ready;
   logic [31:0] f_rdata;
   logic        f_err;
   logic        f_busy;

   dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) u_dut (
      .i_clk       (clk),
      .i_s_rst     (i_s_rst),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_we    (i_req_we),
      .i_req_addr  (i_req_addr),
      .i_req_wdata (i_req_wdata),
      .i_req_be    (i_req_be),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_rdata (o_rsp_rdata),
      .o_rsp_err   (o_rsp_err),
      .o_busy      (o_busy)
   );

   dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_fast (
      .i_clk       (clk),
      .i_s_rst     (f_rst),
      .i_req_valid (f_valid),
      .o_req_ready (f_ready),
      .i_req_we    (f_we),
      .i_req_addr  (f_addr),
      .i_req_wdata (f_wdata),
      .i_req_be    (f_be),
      .o_rsp_valid (f_rsp_valid),
      .i_rsp_ready (f_rsp_ready),
      .o_rsp_rdata (f_rdata),
      .o_rsp_err   (f_err),
      .o_busy      (f_busy)
   );

   int checks = 0;
   int passes = 0;

   task automatic chk(input bit ok, input string nm,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- transaction-level reference model ----------------
   bit [31:0] mdl [int];

   function automatic bit addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 0);
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a >> 2) & ((32'd1 << AW) - 1));
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be);
      int k;
      k = word_of(a);
`ifdef DMEM_BYTE_WRITE_EN
      if (mdl.exists(k)) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mdl[k][8*b +: 8] = d[8*b +: 8];
      end else if (be == 4'hF) begin
         mdl[k] = d;
      end
`else
      if (be === 4'bxxxx) mdl[k] = d;
      else mdl[k] = d;
`endif
   endtask

   bit          mon_en = 1'b0;
   bit          after_rst = 1'b1;
   bit          pend = 1'b0;
   int          cyc = 0;
   int          p_from;
   bit          p_we, p_err, p_known;
   logic [31:0] p_addr, p_wdata, p_rdata;
   logic [3:0]  p_be;

   always @(negedge clk) begin
      if (mon_en) begin
         chk(o_busy == !o_req_ready, "busy_vs_ready", o_busy, !o_req_ready);
         if (after_rst)
            chk(o_rsp_rdata == 0 && o_rsp_err == 0, "reset_data",
                o_rsp_rdata, 0);
         if (pend && cyc >= p_from) begin
            chk(o_rsp_valid == 1 && o_req_ready == 0, "resp_phase",
                {o_rsp_valid, o_req_ready}, 2'b10);
            chk(o_rsp_err == p_err, "rsp_err", o_rsp_err, p_err);
            if (p_we || p_err)
               chk(o_rsp_rdata == 0, "rsp_rdata_zero", o_rsp_rdata, 0);
            else if (p_known)
               chk(o_rsp_rdata == p_rdata, "rsp_rdata", o_rsp_rdata, p_rdata);
            if (cyc == p_from && p_we && !p_err)
               model_write(p_addr, p_wdata, p_be);
         end else if (pend) begin
            chk(o_rsp_valid == 0 && o_req_ready == 0, "wait_phase",
                {o_rsp_valid, o_req_ready}, 2'b00);
         end else begin
            chk(o_rsp_valid == 0 && o_req_ready == 1, "idle_phase",
                {o_rsp_valid, o_req_ready}, 2'b01);
         end
         if (i_s_rst) begin
            pend      = 1'b0;
            after_rst = 1'b1;
         end else begin
            after_rst = 1'b0;
            if (pend && cyc >= p_from && i_rsp_ready) begin
               pend = 1'b0;
            end else if (!pend && i_req_valid) begin
               pend    = 1'b1;
               p_from  = cyc + W + 1;
               p_we    = i_req_we;
               p_addr  = i_req_addr;
               p_wdata = i_req_wdata;
               p_be    = i_req_be;
               p_err   = addr_bad(i_req_addr);
               p_known = mdl.exists(word_of(i_req_addr));
               p_rdata = p_known ? mdl[word_of(i_req_addr)] : 32'd0;
            end
         end
      end
      cyc++;
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input int hold, input bit poke,
                      output logic [31:0] rd, output bit e, output int lat);
      int t;
      step();
      i_req_we    = we;
      i_req_addr  = addr;
      i_req_wdata = wdata;
      i_req_be    = be;
      i_req_valid = 1'b1;
      i_rsp_ready = 1'b0;
      t = 0;
      while (!o_req_ready && t < 50) begin
         step();
         t++;
      end
      if (!o_req_ready) chk(1'b0, "accept_timeout", o_req_ready, 1);
      step();
      i_req_valid = 1'b0;
      i_req_we    = 1'($urandom);
      i_req_addr  = $urandom;
      i_req_wdata = $urandom;
      i_req_be    = 4'($urandom);
      lat = 1;
      while (!o_rsp_valid && lat < 40) begin
         step();
         lat++;
      end
      if (!o_rsp_valid) chk(1'b0, "rsp_timeout", o_rsp_valid, 1);
      rd = o_rsp_rdata;
      e  = o_rsp_err;
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            i_req_valid = 1'b1;
            i_req_we    = 1'b1;
            i_req_addr  = 32'h0;
            i_req_wdata = 32'hBAD0BAD0;
            i_req_be    = 4'hF;
         end
         step();
         chk(o_rsp_valid && o_rsp_rdata == rd && o_rsp_err == e,
             "hold_stable", o_rsp_rdata, rd);
         if (poke) chk(o_req_ready == 0, "stall_ready", o_req_ready, 0);
      end
      i_req_valid = 1'b0;
      i_rsp_ready = 1'b1;
      step();
      i_rsp_ready = 1'b0;
      if (poke)
         chk(!o_rsp_valid && o_req_ready, "stall_release",
             {o_rsp_valid, o_req_ready}, 2'b01);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      bit          e;
      int          lat;
      int          nresp;
      int          r;

      i_s_rst = 1'b1; i_req_valid = 1'b0; i_rsp_ready = 1'b0;
      i_req_we = 1'b0; i_req_addr = '0; i_req_wdata = '0; i_req_be = '0;
      f_rst = 1'b1; f_valid = 1'b0; f_rsp_ready = 1'b0;
      f_we = 1'b0; f_addr = '0; f_wdata = '0; f_be = '0;

      @(posedge clk);
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      step();
      chk(o_req_ready && !o_rsp_valid && !o_busy &&
          o_rsp_rdata == 0 && !o_rsp_err, "reset_values",
          {o_req_ready, o_rsp_valid, o_busy, o_rsp_err}, 4'b1000);
      i_s_rst = 1'b0;
      f_rst   = 1'b0;

      for (int i = 0; i < 32; i++) begin
         if (i == 0)      a = 32'hA5A50000;
         else if (i == 8) a = 32'h0;
         else             a = $urandom;
         txn(1'b1, 32'(i * 4), a, 4'hF, 0, 1'b0, rd, e, lat);
      end

      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, e, lat);
      chk(lat == 3, "write_latency", lat, 3);
      chk(rd == 0 && !e, "write_rsp", rd, 0);
      txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, e, lat);
      chk(lat == 3, "read_latency", lat, 3);
      chk(rd == 32'hDEADBEEF && !e, "read_back", rd, 32'hDEADBEEF);

      txn(1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0, rd, e, lat);
      chk(e && rd == 0, "misaligned", {rd[30:0], e}, 1);
      txn(1'b1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF, 0, 1'b0, rd, e, lat);
      chk(e && rd == 0, "out_of_range", {rd[30:0], e}, 1);
      txn(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd, e, lat);
      chk(rd == 32'hA5A50000 && !e, "array_unchanged", rd, 32'hA5A50000);

      txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1, rd, e, lat);
      chk(rd == 32'hDEADBEEF && !e, "stall_data", rd, 32'hDEADBEEF);

      step();
      i_req_we = 1'b1; i_req_addr = 32'h20;
      i_req_wdata = 32'h12345678; i_req_be = 4'hF;
      i_req_valid = 1'b1;
      step();
      i_req_valid = 1'b0;
      i_s_rst = 1'b1;
      step();
      chk(o_req_ready && !o_rsp_valid && !o_busy &&
          o_rsp_rdata == 0 && !o_rsp_err, "abort_reset",
          {o_req_ready, o_rsp_valid, o_busy, o_rsp_err}, 4'b1000);
      i_s_rst = 1'b0;
      txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, rd, e, lat);
      chk(rd == 0 && !e, "abort_no_write", rd, 0);

      txn(1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 0, 1'b0, rd, e, lat);
      txn(1'b1, 32'h40, 32'h00000000, 4'b0101, 0, 1'b0, rd, e, lat);
      txn(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0, rd, e, lat);
`ifdef DMEM_BYTE_WRITE_EN
      chk(rd == 32'hFF00FF00, "byte_enable", rd, 32'hFF00FF00);
`else
      chk(rd == 32'h00000000, "full_word", rd, 32'h00000000);
`endif

      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0)
            a = {22'd0, 5'($urandom_range(0, 31)), 3'd0} |
                32'($urandom_range(1, 3));
         else if (r == 1)
            a = $urandom | 32'h0000_1000;
         else
            a = 32'($urandom_range(0, 31)) << 2;
         txn(1'($urandom), a, $urandom, 4'($urandom),
             $urandom_range(0, 3), 1'b0, rd, e, lat);
         chk(lat == W + 1, "rand_latency", lat, W + 1);
      end

      step();
      f_we = 1'b0; f_addr = 32'h0; f_valid = 1'b1; f_rsp_ready = 1'b1;
      nresp = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk(f_busy == 1'(i % 2), "fast_busy", f_busy, 1'(i % 2));
         chk(f_rsp_valid == 1'(i % 2), "fast_valid", f_rsp_valid, 1'(i % 2));
         if (f_rsp_valid) begin
            nresp++;
            chk(!f_err, "fast_err", f_err, 0);
         end
      end
      @(posedge clk);
      #1;
      f_valid = 1'b0;
      chk(nresp == 4, "fast_count", nresp, 4);

      step();
      step();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
